e_q_clk_gen: RTL and testbench

//  Generates the 6809E quadrature bus clocks E and Q from the fast PLL clock i_clk.

---
 rtl/mtl1_clk_pkg.sv | 18 +
 rtl/phase_timer.sv | 50 +++++
 rtl/e_q_clk_gen.sv | 144 ++++++++++++++
 tb/tb_e_q_clk_gen.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/mtl1_clk_pkg.sv
// Shared definitions for the 6809E bus clock generator.
// Holds the quarter-phase codes seen on o_phase and a helper that gives a
// safe counter width for small terminal counts.
package mtl1_clk_pkg;

   // Quarter-phase codes, named after the E/Q levels they produce.
   localparam logic [1:0] PH_E0Q0 = 2'd0;
   localparam logic [1:0] PH_E0Q1 = 2'd1;
   localparam logic [1:0] PH_E1Q1 = 2'd2;
   localparam logic [1:0] PH_E1Q0 = 2'd3;

   // Width needed to count 0..n-1.
   // Never less than one bit, so a degenerate count still yields a legal vector.
   function automatic int cntWidth(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/phase_timer.sv
// Quarter-phase tick counter for the E/Q clock generator.
// Counts 0..PHASE_TICKS-1 while enabled and wraps to 0 after the last tick.
// o_tc marks the last tick of a quarter, and only while the counter is advancing.
// Ports:
//   i_clk    fast PLL clock
//   i_rst_n  asynchronous active-low reset
//   i_en     advance the counter this cycle
//   i_clr    force the counter to 0; overrides i_en
//   o_tc     terminal count, one cycle per quarter-phase
module phase_timer
   import mtl1_clk_pkg::*;
#(
   parameter int PHASE_TICKS = 25
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_en,
   input  logic i_clr,
   output logic o_tc
);

   localparam int              W    = cntWidth(PHASE_TICKS);
   localparam logic [W-1:0]    LAST = W'(PHASE_TICKS - 1);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   // Next count: clear wins.
   // Otherwise the counter wraps at the last tick so each quarter is exactly PHASE_TICKS long.
   always_comb begin
      count_d = count_q;
      if (i_clr) begin
         count_d = '0;
      end else if (i_en) begin
         count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
      end
   end

   // Count register; reset puts the quarter back at its first tick.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign o_tc = i_en && !i_clr && (count_q == LAST);

endmodule

// File: rtl/e_q_clk_gen.sv
// 6809E quadrature bus clock generator.
// Produces E and Q from the fast clock, with Q leading E by one quarter-phase.
// E-high can be stretched in quarter-phase steps, and the clock can be stopped
// cleanly at the end of a bus cycle.
// Single-cycle strobes mark the E edges.
// Every output comes from a register.
// Ports:
//   i_clk        fast PLL clock
//   i_rst_n      asynchronous active-low reset
//   i_enable     run E/Q; when low, stop once the current cycle completes
//   i_stretch    MRDY-style request to hold the E-high/Q-low quarter longer
//   o_e_clk      E clock
//   o_q_clk      Q clock
//   o_e_rise     strobe in the cycle E becomes 1
//   o_e_fall     strobe in the cycle E becomes 0
//   o_phase      current quarter (0 E0Q0, 1 E0Q1, 2 E1Q1, 3 E1Q0)
//   o_stretched  high while the E1Q0 quarter is extended
module e_q_clk_gen
   import mtl1_clk_pkg::*;
#(
   parameter int PHASE_TICKS = 25,
   parameter int MAX_STRETCH = 8
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_enable,
   input  logic       i_stretch,
   output logic       o_e_clk,
   output logic       o_q_clk,
   output logic       o_e_rise,
   output logic       o_e_fall,
   output logic [1:0] o_phase,
   output logic       o_stretched
);

   typedef enum logic [1:0] {
      E0Q0 = PH_E0Q0,
      E0Q1 = PH_E0Q1,
      E1Q1 = PH_E1Q1,
      E1Q0 = PH_E1Q0
   } phase_e;

   localparam int           SW          = cntWidth(MAX_STRETCH + 1);
   localparam logic [SW-1:0] STRETCH_MAX = SW'(MAX_STRETCH);

   phase_e        phase_q, phase_d;
   logic          idle_q, idle_d;
   logic [SW-1:0] stretchCnt_q, stretchCnt_d;
   logic          stretched_q, stretched_d;
   logic          eClk_q, eClk_d;
   logic          qClk_q, qClk_d;
   logic          eRise_q, eRise_d;
   logic          eFall_q, eFall_d;
   logic          tc;
   logic          timerClr;

   // While stopped, the tick counter is held at zero.
   // The first enabled cycle therefore starts a full-length E0Q0 quarter.
   assign timerClr = idle_q && !i_enable;

   phase_timer #(
      .PHASE_TICKS(PHASE_TICKS)
   ) u_timer (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_en    (!timerClr),
      .i_clr   (timerClr),
      .o_tc    (tc)
   );

   // Phase FSM and stretch bookkeeping.
   // Decisions are taken only at the last tick of a quarter.
   // Enable is looked at only when leaving E0Q0, so a stop never cuts E short.
   // Stretch is looked at only when leaving E1Q0.
   // The E/Q levels and strobes are decoded from the next phase, so they
   // register in the same cycle as o_phase.
   always_comb begin
      phase_d      = phase_q;
      idle_d       = idle_q && !i_enable;
      stretchCnt_d = stretchCnt_q;
      stretched_d  = stretched_q;
      if (tc) begin
         case (phase_q)
            E0Q0: begin
               if (i_enable) begin
                  phase_d = E0Q1;
               end else begin
                  idle_d = 1'b1;
               end
            end
            E0Q1: phase_d = E1Q1;
            E1Q1: phase_d = E1Q0;
            E1Q0: begin
               if (i_stretch && (stretchCnt_q < STRETCH_MAX)) begin
                  stretchCnt_d = stretchCnt_q + 1'b1;
                  stretched_d  = 1'b1;
               end else begin
                  phase_d      = E0Q0;
                  stretchCnt_d = '0;
                  stretched_d  = 1'b0;
               end
            end
            default: phase_d = E0Q0;
         endcase
      end
      eClk_d  = (phase_d == E1Q1) || (phase_d == E1Q0);
      qClk_d  = (phase_d == E0Q1) || (phase_d == E1Q1);
      eRise_d = tc && (phase_q == E0Q1);
      eFall_d = tc && (phase_q == E1Q0) && (phase_d == E0Q0);
   end

   // State and output registers.
   // An asynchronous reset drops E and Q immediately.
   // Restart after reset is identical to power-up.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         phase_q      <= E0Q0;
         idle_q       <= 1'b0;
         stretchCnt_q <= '0;
         stretched_q  <= 1'b0;
         eClk_q       <= 1'b0;
         qClk_q       <= 1'b0;
         eRise_q      <= 1'b0;
         eFall_q      <= 1'b0;
      end else begin
         phase_q      <= phase_d;
         idle_q       <= idle_d;
         stretchCnt_q <= stretchCnt_d;
         stretched_q  <= stretched_d;
         eClk_q       <= eClk_d;
         qClk_q       <= qClk_d;
         eRise_q      <= eRise_d;
         eFall_q      <= eFall_d;
      end
   end

   assign o_e_clk     = eClk_q;
   assign o_q_clk     = qClk_q;
   assign o_e_rise    = eRise_q;
   assign o_e_fall    = eFall_q;
   assign o_phase     = phase_q;
   assign o_stretched = stretched_q;

endmodule

// File: tb/tb_e_q_clk_gen.sv
// Self-checking bench for the E/Q clock generator.
// Inputs are driven randomly and every cycle is compared with a quarter-phase
// countdown model of the clock rules.
// Directed measurements cover Q start latency, E-high width with and without
// maximum stretch, and asynchronous reset while E is high.
module tb_e_q_clk_gen;

   localparam int PT = 25;
   localparam int MS = 8;

   logic       clk = 1'b0;
   logic       rstN = 1'b0;
   logic       enable = 1'b0;
   logic       stretch = 1'b0;
   logic       eClk, qClk, eRise, eFall, stretched;
   logic [1:0] phase;

   e_q_clk_gen #(
      .PHASE_TICKS(PT),
      .MAX_STRETCH(MS)
   ) dut (
      .i_clk       (clk),
      .i_rst_n     (rstN),
      .i_enable    (enable),
      .i_stretch   (stretch),
      .o_e_clk     (eClk),
      .o_q_clk     (qClk),
      .o_e_rise    (eRise),
      .o_e_fall    (eFall),
      .o_phase     (phase),
      .o_stretched (stretched)
   );

   // 100 MHz fast clock
   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;

   // Reference model state.
   // mLeft counts the clock edges remaining until the current quarter ends.
   int mPhase, mLeft, mStretchCnt;
   bit mIdle, mStretched, mRise, mFall;

   // Observation bookkeeping for the directed timing measurements
   int cycleCount, firstQRise, eRiseAt, maxEHigh;
   logic prevE, prevQ;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got === exp) passes++;
      else $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   task automatic modelReset();
      mPhase = 0; mLeft = PT; mIdle = 0; mStretchCnt = 0;
      mStretched = 0; mRise = 0; mFall = 0;
      cycleCount = 0; firstQRise = -1; eRiseAt = -1; prevE = 0; prevQ = 0;
   endtask

   // One clock edge of the clock rules, using the inputs present at that edge
   task automatic modelStep(input bit en, input bit st);
      mRise = 0; mFall = 0;
      if (!(mIdle && !en)) begin
         mIdle = 0;
         mLeft--;
         if (mLeft == 0) begin
            mLeft = PT;
            case (mPhase)
               0: if (en) mPhase = 1; else mIdle = 1;
               1: begin mPhase = 2; mRise = 1; end
               2: mPhase = 3;
               default: begin
                  if (st && mStretchCnt < MS) begin
                     mStretchCnt++; mStretched = 1;
                  end else begin
                     mPhase = 0; mStretchCnt = 0; mStretched = 0; mFall = 1;
                  end
               end
            endcase
         end
      end
   endtask

   function automatic logic [6:0] expected();
      return {(mPhase >= 2), (mPhase == 1 || mPhase == 2), mRise, mFall, 2'(mPhase), mStretched};
   endfunction

   // Drive random inputs for n cycles.
   // enPct and strPct are the per-cycle percentage chances that each input is high.
   task automatic applyStimulus(input int n, input int enPct, input int strPct);
      for (int i = 0; i < n; i++) begin
         enable  = ($urandom_range(99) < enPct);
         stretch = ($urandom_range(99) < strPct);
         @(posedge clk);
         modelStep(enable, stretch);
         cycleCount++;
         @(negedge clk);
         checkOutput("outputs", {eClk, qClk, eRise, eFall, phase, stretched}, expected());
         if (qClk && !prevQ && firstQRise < 0) firstQRise = cycleCount;
         if (eClk && !prevE) eRiseAt = cycleCount;
         if (!eClk && prevE && eRiseAt >= 0 && (cycleCount - eRiseAt) > maxEHigh)
            maxEHigh = cycleCount - eRiseAt;
         prevE = eClk;
         prevQ = qClk;
      end
   endtask

   // Run until E is high, then pulse reset between clock edges.
   // The outputs must clear with no clock edge.
   task automatic applyReset();
      int tries = 0;
      while (mPhase != 2 && tries < 400) begin
         applyStimulus(1, 100, 0);
         tries++;
      end
      checkOutput("reachEHigh", {31'd0, eClk}, 32'd1);
      #2 rstN = 1'b0;
      #1 checkOutput("asyncReset", {eClk, qClk, eRise, eFall, phase, stretched}, 7'd0);
      @(posedge clk);
      @(negedge clk);
      checkOutput("heldReset", {eClk, qClk, eRise, eFall, phase, stretched}, 7'd0);
      rstN = 1'b1;
      modelReset();
   endtask

   initial begin
      #5ms;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      modelReset();
      repeat (3) @(negedge clk);
      checkOutput("resetE", {31'd0, eClk}, 32'd0);
      checkOutput("resetQ", {31'd0, qClk}, 32'd0);
      checkOutput("resetRise", {31'd0, eRise}, 32'd0);
      checkOutput("resetFall", {31'd0, eFall}, 32'd0);
      checkOutput("resetPhase", {30'd0, phase}, 32'd0);
      checkOutput("resetStretched", {31'd0, stretched}, 32'd0);
      rstN = 1'b1;

      // Free-running clock with no stretch: Q starts one quarter in and E is high for two quarters
      maxEHigh = 0;
      applyStimulus(500, 100, 0);
      checkOutput("firstQRise", firstQRise, PT);
      checkOutput("normalEHigh", maxEHigh, 2 * PT);

      // Stretch held: E high is bounded by the maximum stretch count
      maxEHigh = 0;
      applyStimulus(700, 100, 100);
      checkOutput("maxEHigh", maxEHigh, (2 + MS) * PT);

      applyStimulus(3000, 100, 50);
      applyStimulus(3000, 100, 10);
      applyStimulus(3000, 97, 30);
      applyStimulus(2000, 50, 50);
      applyStimulus(1500, 0, 20);
      applyStimulus(2000, 100, 30);

      applyReset();
      applyStimulus(300, 100, 0);
      checkOutput("firstQRiseAfterReset", firstQRise, PT);

      applyStimulus(3000, 80, 40);
      applyReset();
      applyStimulus(1000, 90, 60);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
